// File: rtl/multi_chan_timer.sv
// Multi-channel down-counting timer: per-channel load, one-shot/auto-reload,
// pause, terminal-count decode and sticky expiry interrupt with software clear.
module multi_chan_timer #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        areset_n,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS*WIDTH-1:0]   data,
  input  logic [CHANNELS-1:0]         auto_reload,
  input  logic [CHANNELS-1:0]         en,
  input  logic [CHANNELS-1:0]         irq_clr,
  output logic [CHANNELS*WIDTH-1:0]   count,
  output logic [CHANNELS-1:0]         tc,
  output logic [CHANNELS-1:0]         irq
);

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_rld;
    logic             r_mode;
    logic             r_irq;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_zero;
    logic             w_expire;

    assign w_data   = data[g*WIDTH +: WIDTH];
    assign w_zero   = (r_cnt == '0);
    // Only a real 1->0 step counts as expiry; loading or holding zero does not.
    assign w_expire = ~load[g] & en[g] & (r_cnt == WIDTH'(1));

    // Next count: load > reload > decrement > hold.
    always_comb begin
      w_cnt_nxt = r_cnt;
      if (load[g]) begin
        w_cnt_nxt = w_data;
      end else if (en[g]) begin
        if (!w_zero) begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
        end else if (r_mode) begin
          w_cnt_nxt = r_rld;
        end
      end
    end

    always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
        r_cnt  <= '0;
        r_rld  <= '0;
        r_mode <= 1'b0;
        r_irq  <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (load[g]) begin
          r_rld  <= w_data;
          r_mode <= auto_reload[g];
        end
        // A coincident expiry beats the clear so no event is lost.
        if (w_expire) begin
          r_irq <= 1'b1;
        end else if (irq_clr[g]) begin
          r_irq <= 1'b0;
        end
      end
    end

    assign count[g*WIDTH +: WIDTH] = r_cnt;
    assign tc[g]                   = w_zero;
    assign irq[g]                  = r_irq;
  end

endmodule

// File: doc/multi_chan_timer.md
# multi_chan_timer

Parametrised multi-channel down-counting timer, the successor to the single 10-bit load/terminal-count timer. Each of CHANNELS independent channels loads a WIDTH-bit start value, counts down once per enabled clock and flags terminal count. Each channel runs in one-shot or auto-reload mode and can be paused. A sticky per-channel interrupt flag with software clear lets a controller or bench poll for expiry without catching single-cycle pulses.

## Interface
- WIDTH, 10, counter width per channel (≥2)
- CHANNELS, 4, number of independent channels (≥1)

- clk  in  1  rising-edge clock
- areset_n  in  1  asynchronous, active-low reset
- load  in  CHANNELS  per-channel load strobe
- data  in  CHANNELS*WIDTH  load value; channel i uses data[i*WIDTH +: WIDTH]
- auto_reload  in  CHANNELS  mode, sampled only when load[i]=1 (0 one-shot, 1 auto-reload)
- en  in  CHANNELS  count enable; 0 pauses channel i
- irq_clr  in  CHANNELS  clears irq[i]
- count  out  CHANNELS*WIDTH  current counter value, channel i at [i*WIDTH +: WIDTH]
- tc  out  CHANNELS  terminal count: tc[i] = (count[i] == 0)
- irq  out  CHANNELS  sticky expiry flag

## Operation
- Per-channel state: cnt (WIDTH), rld (WIDTH), mode (1), irq (1). Channels share nothing but clk/areset_n.
- Priority per channel, per edge: load > reload > decrement > hold.
- load[i]=1: cnt←data_i, rld←data_i, mode←auto_reload[i]. Applies regardless of en[i]; restarts a running count.
- load[i]=0, en[i]=1:
  - cnt≠0: cnt←cnt−1.
  - cnt=0, mode=1: cnt←rld (period rld+1 cycles).
  - cnt=0, mode=0: hold at 0.
- load[i]=0, en[i]=0: cnt holds; no expiry event.
- Expiry event: load[i]=0 && en[i]=1 && cnt=1 (the 1→0 transition). Loading 0 directly, or holding at 0, is not an expiry.
- rld=0 in auto-reload: cnt stays 0, tc held 1, no expiry events (degenerate, legal).
- irq[i]: set on expiry event; else cleared by irq_clr[i]=1; else holds. Set wins over simultaneous clear.
- Unsigned arithmetic only; decrement never wraps below 0.

## Timing
- Reset (areset_n=0, asynchronous, immediate): cnt=0, rld=0, mode=0, irq=0 in all channels → count=0, tc=all ones, irq=0. Reset mid-count aborts the count; first edge after release behaves as from reset.
- All state updates on rising clk; count and tc are direct decodes of registers (no combinational path from inputs to outputs).
- load at edge k: count=data_i after edge k; with en held 1, tc rises after edge k+N (N=data_i), i.e. N cycles after load.
- irq rises on the same edge cnt goes 1→0 (coincident with tc rising).
- irq_clr takes effect at the next edge; irq low from then unless a new expiry coincides.
- Auto-reload: tc high exactly one cycle per period when en continuous; count sequence N, N−1, …, 0, N, ….
- Pausing at cnt=0 in auto-reload holds tc high until en returns.

## Test plan
- Reset then channel 0 load=1, data=3, auto_reload=0, en=1 for one cycle, then load=0 → count 3,2,1,0; tc[0] rises 3 cycles after load and stays high; irq[0] rises with tc and stays; other channels count=0, irq=0.
- Channel 1 load data=2, auto_reload=1, en=1 → count 2,1,0,2,1,0,…; tc[1] high every 3rd cycle; irq[1] set on first 1→0; irq_clr pulse mid-period clears it, next expiry sets it again; irq_clr asserted on the expiry edge leaves irq[1]=1.
- Channel 2 load data=5, en=1 for 2 cycles, en=0 for 4 cycles, en=1 → count 5,4,3 held 4 cycles, then 2,1,0; tc[2] at cycle 9 after load.
- Reload mid-count: channel 3 load 10, after 4 decrements load 2 with auto_reload=1 → count jumps to 2, then 1,0,2; mode switches to auto-reload; load of 0 afterwards → tc=1, irq unchanged.
- Reset mid-operation: all channels counting, drive areset_n=0 between edges → count=0, tc=all ones, irq=0 immediately, before the next clk edge; after release, counters hold 0 until loaded.
- Parameter sweep WIDTH=4, CHANNELS=1 and WIDTH=16, CHANNELS=8: load max value (2^WIDTH−1) → tc after exactly 2^WIDTH−1 enabled cycles, no wrap.
